// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
//   req   : fetch request (fetch unit -> memory)
//   addr  : word-aligned fetch address (fetch unit -> memory)
//   ack   : read data valid this cycle (memory -> fetch unit)
//   rdata : instruction word (memory -> fetch unit)
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory bus and
// presents if_pc/if_inst to the IF/ID register, honouring stall/flush/branch.
//   clk, rst        : clock, synchronous active-high reset
//   stall[5:0]      : pipeline stall vector (bit 0 holds the fetch unit)
//   flush, new_pc   : exception redirect
//   branch_flag_i   : taken branch resolved in ID, target on branch_target_i
//   imem            : instruction memory bus (master side)
//   if_pc, if_inst  : PC/instruction to IF/ID (if_inst = 0 is a bubble)
//   stallreq_if     : asserted while a fetch is outstanding
// if_pc, if_inst, stallreq_if and the bus outputs are combinational from state
// and imem.ack so a zero-wait ack delivers its word in the same cycle.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [31:0]          new_pc,
  input  logic                 branch_flag_i,
  input  logic [31:0]          branch_target_i,
  if_fetch_unit_if.master      imem,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_inst,
  output logic                 stallreq_if
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {ST_START, ST_REQ, ST_HOLD, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]   hold_inst_q, hold_inst_d;
  logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   fetch_addr;
  logic              unused_stall;

  // Only the fetch-unit hold bit matters here; IF/ID handles bit 1 itself.
  assign unused_stall = ^stall[5:1];

  // Sequential PC (wraps naturally) or taken-branch target.
  assign next_pc = branch_flag_i ? branch_target_i : pc_q + XLEN'(4);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_START;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_inst_q  <= '0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state and output logic; flush outranks stall, stall outranks branch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    drain_addr_d = drain_addr_q;
    fetch_addr   = pc_q;
    imem.req     = 1'b0;
    if_pc        = '0;
    if_inst      = '0;
    stallreq_if  = 1'b0;

    unique case (state_q)
      ST_START: begin
        state_d = ST_REQ;
        if (flush) begin
          pc_d        = new_pc;
          hold_pc_d   = '0;
          hold_inst_d = '0;
        end
      end

      ST_REQ: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          hold_pc_d   = pc_q;
          hold_inst_d = imem.rdata;
          if (flush) begin
            // Fetched word belongs to the squashed path: present a bubble.
            pc_d        = new_pc;
            hold_pc_d   = '0;
            hold_inst_d = '0;
          end else begin
            if_pc   = pc_q;
            if_inst = imem.rdata;
            if (stall[0]) begin
              state_d = ST_HOLD;
            end else begin
              pc_d = next_pc;
            end
          end
        end else begin
          stallreq_if = 1'b1;
          if (flush) begin
            // Request still in flight: remember its address and wait it out.
            pc_d         = new_pc;
            hold_pc_d    = '0;
            hold_inst_d  = '0;
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end
      end

      ST_HOLD: begin
        if (flush) begin
          pc_d        = new_pc;
          hold_pc_d   = '0;
          hold_inst_d = '0;
          state_d     = ST_REQ;
        end else begin
          // Keep the word visible through the release cycle for IF/ID.
          if_pc   = hold_pc_q;
          if_inst = hold_inst_q;
          if (!stall[0]) begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end

      ST_DRAIN: begin
        imem.req    = 1'b1;
        fetch_addr  = drain_addr_q;
        stallreq_if = 1'b1;
        if (flush) begin
          pc_d        = new_pc;
          hold_pc_d   = '0;
          hold_inst_d = '0;
        end
        // Ack retires the abandoned request; its data is dropped.
        if (imem.ack) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_START;
    endcase
  end

  assign imem.addr = {fetch_addr[XLEN-1:2], 2'b00};
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  int          n_checks = 0;
  int          n_fail   = 0;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem            (bus.master),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flush in a REQ cycle with a zero-wait ack: next cycle fetches target.
  task automatic redirect(input logic [31:0] target);
    flush = 1'b1; new_pc = target; bus.ack = 1'b1; bus.rdata = 32'hDEAD_DEAD;
    tick();
    flush = 1'b0; new_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag_i = 1'b0; branch_target_i = '0; bus.ack = 1'b0; bus.rdata = '0;
    tick(); tick();
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", bus.req); end
    n_checks++; if (bus.addr !== RPC) begin n_fail++; $display("FAIL rst_addr got %h want %h", bus.addr, RPC); end
    n_checks++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out got pc=%h inst=%h want 0", if_pc, if_inst); end
    n_checks++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL rst_stallreq got %b want 0", stallreq_if); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL start_req got %b want 0", bus.req); end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = RPC + 32'(4 * i);
      bus.ack = 1'b1; bus.rdata = 32'h0100_0000 + 32'(i);
      #1;
      n_checks++; if (bus.req !== 1'b1 || bus.addr !== exp_pc) begin n_fail++; $display("FAIL seq_bus[%0d] got req=%b addr=%h want 1 %h", i, bus.req, bus.addr, exp_pc); end
      n_checks++; if (if_pc !== exp_pc || if_inst !== 32'h0100_0000 + 32'(i)) begin n_fail++; $display("FAIL seq_out[%0d] got pc=%h inst=%h want %h %h", i, if_pc, if_inst, exp_pc, 32'h0100_0000 + 32'(i)); end
      n_checks++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL seq_stallreq[%0d] got %b want 0", i, stallreq_if); end
      tick();
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      bus.ack = 1'b0; bus.rdata = 32'hFFFF_FFFF;
      #1;
      n_checks++; if (stallreq_if !== 1'b1 || if_inst !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL wait_out[%0d] got sr=%b pc=%h inst=%h want 1 0 0", i, stallreq_if, if_pc, if_inst); end
      n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'hBFC0_000C) begin n_fail++; $display("FAIL wait_bus[%0d] got req=%b addr=%h want 1 bfc0000c", i, bus.req, bus.addr); end
      tick();
    end
    bus.ack = 1'b1; bus.rdata = 32'hCAFE_0001;
    #1;
    n_checks++; if (if_inst !== 32'hCAFE_0001 || if_pc !== 32'hBFC0_000C || stallreq_if !== 1'b0) begin n_fail++; $display("FAIL wait_ack got pc=%h inst=%h sr=%b want bfc0000c cafe0001 0", if_pc, if_inst, stallreq_if); end
    n_checks++; if (bus.addr !== 32'hBFC0_000C) begin n_fail++; $display("FAIL wait_ack_addr got %h want bfc0000c", bus.addr); end
    tick();
  endtask

  task automatic test_stall_hold();
    flush = 1'b1; new_pc = 32'h100; bus.ack = 1'b1; bus.rdata = 32'h5555_5555;
    #1;
    n_checks++; if (if_inst !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL flush_ack_out got pc=%h inst=%h want 0 0", if_pc, if_inst); end
    tick();
    flush = 1'b0; stall = 6'b000011; bus.ack = 1'b1; bus.rdata = 32'h0000_1234;
    #1;
    n_checks++; if (if_pc !== 32'h100 || if_inst !== 32'h1234) begin n_fail++; $display("FAIL stall_fetch got pc=%h inst=%h want 100 1234", if_pc, if_inst); end
    tick();
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.req !== 1'b0 || stallreq_if !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got req=%b sr=%b want 0 0", i, bus.req, stallreq_if); end
      n_checks++; if (if_pc !== 32'h100 || if_inst !== 32'h1234) begin n_fail++; $display("FAIL hold_out[%0d] got pc=%h inst=%h want 100 1234", i, if_pc, if_inst); end
      tick();
    end
    stall = '0;
    #1;
    n_checks++; if (if_pc !== 32'h100 || bus.req !== 1'b0) begin n_fail++; $display("FAIL hold_release got pc=%h req=%b want 100 0", if_pc, bus.req); end
    tick();
    bus.ack = 1'b1; bus.rdata = 32'h0000_5678;
    #1;
    n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h104 || if_pc !== 32'h104) begin n_fail++; $display("FAIL hold_next got req=%b addr=%h pc=%h want 1 104 104", bus.req, bus.addr, if_pc); end
    tick();
  endtask

  task automatic test_branch();
    redirect(32'h40);
    bus.ack = 1'b1; bus.rdata = 32'h1000_0040;
    #1;
    n_checks++; if (if_pc !== 32'h40) begin n_fail++; $display("FAIL br_first got %h want 40", if_pc); end
    tick();
    branch_flag_i = 1'b1; branch_target_i = 32'h2000; bus.rdata = 32'h1000_0044;
    #1;
    n_checks++; if (if_pc !== 32'h44 || if_inst !== 32'h1000_0044) begin n_fail++; $display("FAIL br_slot got pc=%h inst=%h want 44 10000044", if_pc, if_inst); end
    tick();
    branch_flag_i = 1'b0; branch_target_i = '0; bus.rdata = 32'h1000_2000;
    #1;
    n_checks++; if (if_pc !== 32'h2000 || bus.addr !== 32'h2000) begin n_fail++; $display("FAIL br_target got pc=%h addr=%h want 2000", if_pc, bus.addr); end
    tick();
    #1;
    n_checks++; if (bus.addr !== 32'h2004) begin n_fail++; $display("FAIL br_after got %h want 2004", bus.addr); end
    tick();
  endtask

  task automatic test_flush_drain();
    redirect(32'h50);
    bus.ack = 1'b0; flush = 1'b1; new_pc = 32'h180;
    #1;
    n_checks++; if (bus.addr !== 32'h50 || stallreq_if !== 1'b1 || if_inst !== 32'h0) begin n_fail++; $display("FAIL fl_cycle got addr=%h sr=%b inst=%h want 50 1 0", bus.addr, stallreq_if, if_inst); end
    tick();
    flush = 1'b0; new_pc = '0;
    #1;
    n_checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h50 || stallreq_if !== 1'b1) begin n_fail++; $display("FAIL drain_wait got req=%b addr=%h sr=%b want 1 50 1", bus.req, bus.addr, stallreq_if); end
    tick();
    bus.ack = 1'b1; bus.rdata = 32'h0BAD_0BAD;
    #1;
    n_checks++; if (if_inst !== 32'h0 || if_pc !== 32'h0 || bus.addr !== 32'h50) begin n_fail++; $display("FAIL drain_ack got pc=%h inst=%h addr=%h want 0 0 50", if_pc, if_inst, bus.addr); end
    tick();
    bus.rdata = 32'h0000_0180;
    #1;
    n_checks++; if (bus.addr !== 32'h180 || if_pc !== 32'h180 || if_inst !== 32'h180) begin n_fail++; $display("FAIL drain_next got addr=%h pc=%h inst=%h want 180", bus.addr, if_pc, if_inst); end
    tick();
  endtask

  task automatic test_rst_in_drain();
    bus.ack = 1'b0; flush = 1'b1; new_pc = 32'h300;
    tick();
    flush = 1'b0; new_pc = '0; rst = 1'b1;
    #1;
    n_checks++; if (bus.addr !== 32'h184 || bus.req !== 1'b1) begin n_fail++; $display("FAIL rd_drain got addr=%h req=%b want 184 1", bus.addr, bus.req); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req !== 1'b0 || bus.addr !== RPC || stallreq_if !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL rd_reset got req=%b addr=%h sr=%b pc=%h inst=%h want 0 %h 0 0 0", bus.req, bus.addr, stallreq_if, if_pc, if_inst, RPC); end
    tick();
    bus.ack = 1'b1; bus.rdata = 32'h0000_0ABC;
    #1;
    n_checks++; if (bus.req !== 1'b1 || bus.addr !== RPC || if_pc !== RPC) begin n_fail++; $display("FAIL rd_first got req=%b addr=%h pc=%h want 1 %h", bus.req, bus.addr, if_pc, RPC); end
    tick();
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    bus.ack = 1'b1; bus.rdata = 32'h0000_0001;
    #1;
    n_checks++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h want fffffffc", if_pc); end
    tick();
    #1;
    n_checks++; if (bus.addr !== 32'h0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got addr=%h pc=%h want 0 0", bus.addr, if_pc); end
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_branch();
    test_flush_drain();
    test_rst_in_drain();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
